// File: rtl/load_use_hazard_unit.sv
// Load-use hazard unit: per-register countdown scoreboard of in-flight load destinations,
// same-cycle stall/bubble generation for Decode and a saturating stall-cycle counter.
module load_use_hazard_unit #(
  parameter int unsigned       REG_AW   = 3,
  parameter int unsigned       OPC_W    = 5,
  parameter int unsigned       LOAD_LAT = 1,
  parameter logic [OPC_W-1:0]  LD_OPC_A = 5'b10000,
  parameter logic [OPC_W-1:0]  LD_OPC_B = 5'b10010,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [OPC_W-1:0]       id_opcode,
  input  logic [REG_AW-1:0]      id_rsrc,
  input  logic [REG_AW-1:0]      id_rdst,
  input  logic                   id_rsrc_used,
  input  logic                   id_rdst_used,
  input  logic                   flush,
  output logic                   freeze_pc,
  output logic                   freeze_ifid,
  output logic                   bubble_idex,
  output logic [2**REG_AW-1:0]   pending,
  output logic [CNT_W-1:0]       stall_count
);

  localparam int unsigned NREG = 2**REG_AW;

  if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
    $error("load_use_hazard_unit: LOAD_LAT must be in 1..7");
  end

  logic [2:0]       r_cnt [NREG];
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_src_busy;
  logic w_dst_busy;
  logic w_hazard;
  logic w_is_load;
  logic w_issue;

  assign w_src_busy = id_rsrc_used && (r_cnt[id_rsrc] != 3'd0);
  assign w_dst_busy = id_rdst_used && (r_cnt[id_rdst] != 3'd0);
  assign w_hazard   = id_valid && !flush && (w_src_busy || w_dst_busy);
  assign w_is_load  = (id_opcode == LD_OPC_A) || (id_opcode == LD_OPC_B);
  // A stalled load must not claim its destination; it retries when the hazard drops.
  assign w_issue    = id_valid && w_is_load && !w_hazard && !flush;

  assign freeze_pc   = w_hazard;
  assign freeze_ifid = w_hazard;
  assign bubble_idex = w_hazard;
  assign stall_count = r_stall_cnt;

  always_comb begin
    pending = '0;
    for (int i = 0; i < NREG; i++) begin
      pending[i] = (r_cnt[i] != 3'd0);
    end
  end

  // Fresh issue to a register restarts its countdown even if it is already counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_issue && (id_rdst == REG_AW'(i))) begin
          r_cnt[i] <= 3'(LOAD_LAT);
        end else if (r_cnt[i] != 3'd0) begin
          r_cnt[i] <= r_cnt[i] - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Bench for load_use_hazard_unit: four instances (LOAD_LAT 1,2,3,7) share stimulus; a
// ready-time model of register availability predicts stalls, pending bits and stall counts.
module tb_load_use_hazard_unit;

  localparam logic [4:0] OP_POP = 5'b10000;
  localparam logic [4:0] OP_LDD = 5'b10010;
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam int unsigned ND = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid, id_rsrc_used, id_rdst_used, flush;
  logic [4:0] id_opcode;
  logic [2:0] id_rsrc, id_rdst;

  logic        fpc  [ND];
  logic        fif  [ND];
  logic        bub  [ND];
  logic [7:0]  pend [ND];
  logic [15:0] sc0, sc1, sc2;
  logic [3:0]  sc3;

  int unsigned lat_t [ND] = '{1, 2, 3, 7};
  int unsigned smax  [ND] = '{65535, 65535, 65535, 15};
  int unsigned ready [ND][8];
  int unsigned stalls[ND];
  int unsigned cyc;
  int          n_chk = 0;
  int          n_pass = 0;

  typedef struct {
    logic       v;
    logic [4:0] op;
    logic [2:0] rs;
    logic [2:0] rd;
    logic       su;
    logic       du;
    logic       fl;
    logic [2:0] exp;  // expected hazard, bit2=LAT1, bit1=LAT2, bit0=LAT3
  } vec_t;

  vec_t tbl[40];

  always #5 clk = ~clk;

  load_use_hazard_unit #(.LOAD_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rsrc(id_rsrc),
    .id_rdst(id_rdst), .id_rsrc_used(id_rsrc_used), .id_rdst_used(id_rdst_used), .flush(flush),
    .freeze_pc(fpc[0]), .freeze_ifid(fif[0]), .bubble_idex(bub[0]), .pending(pend[0]),
    .stall_count(sc0)
  );
  load_use_hazard_unit #(.LOAD_LAT(2)) u_l2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rsrc(id_rsrc),
    .id_rdst(id_rdst), .id_rsrc_used(id_rsrc_used), .id_rdst_used(id_rdst_used), .flush(flush),
    .freeze_pc(fpc[1]), .freeze_ifid(fif[1]), .bubble_idex(bub[1]), .pending(pend[1]),
    .stall_count(sc1)
  );
  load_use_hazard_unit #(.LOAD_LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rsrc(id_rsrc),
    .id_rdst(id_rdst), .id_rsrc_used(id_rsrc_used), .id_rdst_used(id_rdst_used), .flush(flush),
    .freeze_pc(fpc[2]), .freeze_ifid(fif[2]), .bubble_idex(bub[2]), .pending(pend[2]),
    .stall_count(sc2)
  );
  load_use_hazard_unit #(.LOAD_LAT(7), .CNT_W(4)) u_l7 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rsrc(id_rsrc),
    .id_rdst(id_rdst), .id_rsrc_used(id_rsrc_used), .id_rdst_used(id_rdst_used), .flush(flush),
    .freeze_pc(fpc[3]), .freeze_ifid(fif[3]), .bubble_idex(bub[3]), .pending(pend[3]),
    .stall_count(sc3)
  );

  function automatic logic [15:0] get_sc(input int d);
    case (d)
      0:       return sc0;
      1:       return sc1;
      2:       return sc2;
      default: return {12'd0, sc3};
    endcase
  endfunction

  function automatic vec_t mk(input logic v, input logic [4:0] op, input logic [2:0] rs,
                              input logic [2:0] rd, input logic su, input logic du,
                              input logic fl, input logic [2:0] exp);
    vec_t t;
    t.v = v; t.op = op; t.rs = rs; t.rd = rd; t.su = su; t.du = du; t.fl = fl; t.exp = exp;
    return t;
  endfunction

  task automatic check(input string nm, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut=%0d cyc=%0d got=%0h exp=%0h", nm, d, cyc, act, exp);
  endtask

  task automatic apply(input logic v, input logic [4:0] op, input logic [2:0] rs,
                       input logic [2:0] rd, input logic su, input logic du, input logic fl);
    id_valid = v; id_opcode = op; id_rsrc = rs; id_rdst = rd;
    id_rsrc_used = su; id_rdst_used = du; flush = fl;
  endtask

  // Register r is unavailable while the current cycle is before its ready time.
  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      logic       haz;
      logic       ld;
      logic [7:0] ep;
      haz = id_valid && !flush &&
            ((id_rsrc_used && cyc < ready[d][id_rsrc]) ||
             (id_rdst_used && cyc < ready[d][id_rdst]));
      ld = (id_opcode == OP_POP) || (id_opcode == OP_LDD);
      for (int r = 0; r < 8; r++) ep[r] = (cyc < ready[d][r]);
      check("hazard", d, {61'd0, fpc[d], fif[d], bub[d]}, {61'd0, haz, haz, haz});
      check("pending", d, {56'd0, pend[d]}, {56'd0, ep});
      check("stall_count", d, {48'd0, get_sc(d)}, 64'(stalls[d]));
      if (haz && stalls[d] < smax[d]) stalls[d]++;
      if (id_valid && !flush && !haz && ld) ready[d][id_rdst] = cyc + 1 + lat_t[d];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_clear();
    for (int d = 0; d < ND; d++) begin
      stalls[d] = 0;
      for (int r = 0; r < 8; r++) ready[d][r] = 0;
    end
  endtask

  initial begin
    tbl[0]  = mk(1, OP_LDD, 0, 3, 0, 0, 0, 3'b000);
    tbl[1]  = mk(1, OP_ADD, 3, 0, 1, 0, 0, 3'b111);
    tbl[2]  = mk(1, OP_ADD, 3, 0, 1, 0, 0, 3'b011);
    tbl[3]  = mk(1, OP_ADD, 3, 0, 1, 0, 0, 3'b001);
    tbl[4]  = mk(1, OP_ADD, 3, 0, 1, 0, 0, 3'b000);
    tbl[5]  = mk(1, OP_POP, 0, 5, 0, 0, 0, 3'b000);
    tbl[6]  = mk(1, OP_ADD, 0, 5, 0, 1, 0, 3'b111);
    tbl[7]  = mk(1, OP_ADD, 0, 5, 0, 1, 0, 3'b011);
    tbl[8]  = mk(1, OP_ADD, 0, 5, 0, 1, 0, 3'b001);
    tbl[9]  = mk(1, OP_ADD, 0, 5, 0, 1, 0, 3'b000);
    tbl[10] = mk(1, OP_LDD, 0, 1, 0, 0, 0, 3'b000);
    tbl[11] = mk(1, OP_LDD, 1, 2, 0, 0, 0, 3'b000);
    tbl[12] = mk(1, OP_ADD, 1, 0, 1, 0, 0, 3'b011);
    tbl[13] = mk(1, OP_ADD, 1, 0, 1, 0, 0, 3'b001);
    tbl[14] = mk(1, OP_ADD, 1, 0, 1, 0, 0, 3'b000);
    tbl[15] = mk(1, OP_LDD, 0, 4, 0, 0, 0, 3'b000);
    tbl[16] = mk(1, OP_ADD, 4, 0, 1, 0, 1, 3'b000);
    tbl[17] = mk(1, OP_ADD, 4, 0, 1, 0, 0, 3'b011);
    tbl[18] = mk(1, OP_ADD, 4, 0, 1, 0, 0, 3'b001);
    tbl[19] = mk(1, OP_ADD, 4, 0, 1, 0, 0, 3'b000);
    tbl[20] = mk(1, OP_LDD, 0, 6, 1, 0, 0, 3'b000);
    tbl[21] = mk(1, OP_LDD, 0, 6, 1, 0, 0, 3'b000);
    tbl[22] = mk(1, OP_ADD, 6, 0, 1, 0, 0, 3'b111);
    tbl[23] = mk(1, OP_ADD, 6, 0, 1, 0, 0, 3'b011);
    tbl[24] = mk(1, OP_ADD, 6, 0, 1, 0, 0, 3'b001);
    tbl[25] = mk(1, OP_ADD, 6, 0, 1, 0, 0, 3'b000);
    tbl[26] = mk(1, OP_LDD, 0, 7, 0, 0, 0, 3'b000);
    tbl[27] = mk(0, OP_LDD, 7, 2, 1, 0, 0, 3'b000);
    tbl[28] = mk(1, OP_ADD, 2, 0, 1, 0, 0, 3'b000);
    tbl[29] = mk(1, OP_LDD, 0, 3, 0, 0, 0, 3'b000);
    tbl[30] = mk(1, OP_LDD, 3, 1, 1, 0, 0, 3'b111);
    tbl[31] = mk(1, OP_LDD, 3, 1, 1, 0, 0, 3'b011);
    tbl[32] = mk(1, OP_LDD, 3, 1, 1, 0, 0, 3'b001);
    tbl[33] = mk(1, OP_LDD, 3, 1, 1, 0, 0, 3'b000);
    tbl[34] = mk(1, OP_ADD, 1, 0, 1, 0, 0, 3'b111);
    tbl[35] = mk(1, OP_ADD, 1, 0, 1, 0, 0, 3'b011);
    tbl[36] = mk(1, OP_ADD, 1, 0, 1, 0, 0, 3'b001);
    tbl[37] = mk(1, OP_ADD, 1, 0, 1, 0, 0, 3'b000);
    tbl[38] = mk(1, OP_LDD, 5, 5, 1, 0, 0, 3'b000);
    tbl[39] = mk(1, OP_ADD, 5, 0, 1, 0, 0, 3'b111);

    cyc = 0;
    model_clear();
    apply(1, OP_ADD, 3, 3, 1, 1, 0);
    #2;
    for (int d = 0; d < ND; d++) begin
      check("reset_freeze", d, {61'd0, fpc[d], fif[d], bub[d]}, 64'd0);
      check("reset_pending", d, {56'd0, pend[d]}, 64'd0);
      check("reset_stall_count", d, {48'd0, get_sc(d)}, 64'd0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed vectors with hand-derived stall patterns for LOAD_LAT 1..3.
    for (int i = 0; i < 40; i++) begin
      apply(tbl[i].v, tbl[i].op, tbl[i].rs, tbl[i].rd, tbl[i].su, tbl[i].du, tbl[i].fl);
      #2;
      for (int d = 0; d < 3; d++) begin
        check($sformatf("vec%0d", i), d, {63'd0, fpc[d]}, {63'd0, tbl[i].exp[2-d]});
      end
      model_step();
      tick();
    end

    for (int i = 0; i < 2000; i++) begin
      logic [4:0] op;
      if ($urandom_range(0, 9) < 4) op = $urandom_range(0, 1) ? OP_LDD : OP_POP;
      else op = 5'($urandom_range(0, 31));
      apply(($urandom_range(0, 9) != 0), op, 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0));
      #2;
      model_step();
      tick();
    end
    check("stall_saturated", 3, {60'd0, sc3}, 64'd15);

    // Asynchronous reset in the middle of a stall.
    apply(1, OP_LDD, 0, 3, 0, 0, 0);
    #2;
    model_step();
    tick();
    apply(1, OP_ADD, 3, 0, 1, 0, 0);
    #2;
    model_step();
    rst = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check("async_rst_freeze", d, {63'd0, fpc[d]}, 64'd0);
      check("async_rst_pending", d, {56'd0, pend[d]}, 64'd0);
      check("async_rst_stall_count", d, {48'd0, get_sc(d)}, 64'd0);
    end
    model_clear();
    tick();
    rst = 1'b1;
    apply(1, OP_ADD, 3, 0, 1, 0, 0);
    #2;
    model_step();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
